// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
// FSM state encodings are plain constants so legacy tools can consume them.
package sobel_pkg;

  localparam int COORD_W_DEF = 16;
  localparam logic [7:0] BORDER_BYTE = 8'h00;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_ISSUE     = 3'd2;
  localparam state_t ST_WAIT_DATA = 3'd3;
  localparam state_t ST_SEND      = 3'd4;
  localparam state_t ST_WAIT_TX   = 3'd5;
  localparam state_t ST_DONE      = 3'd6;

endpackage

// File: rtl/sobel_frame_sequencer_pixel_scan.sv
// Raster-order window-centre counter with border and last-pixel flags.
// Moves only on clr or adv; wraps back to (0,0) after the last pixel.
module pixel_scan_counter
  import sobel_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  input  logic [COORD_W-1:0] h,
  input  logic [COORD_W-1:0] w,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               is_border,
  output logic               is_last
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic               last_row, last_col;

  assign last_row  = (row_q == h - ONE);
  assign last_col  = (col_q == w - ONE);
  assign is_last   = last_row && last_col;
  // Frames narrower than 3 in either axis fall out as all-border here.
  assign is_border = (row_q == '0) || last_row || (col_q == '0) || last_col;
  assign row       = row_q;
  assign col       = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (adv) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Loads a frame from UART byte pulses, then streams one Sobel byte per pixel in raster order.
// Interior pixels wait PIPE_LAT cycles for sobel_data; SEND stalls while tx_active is high.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int PIPE_LAT = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] H,
  input  logic [COORD_W-1:0] W,
  input  logic               rx_valid,
  output logic               all_loaded,
  output logic [COORD_W-1:0] read_H,
  output logic [COORD_W-1:0] read_W,
  input  logic [7:0]         sobel_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_active,
  input  logic               tx_done,
  output logic               frame_done,
  output logic               rx_overrun
);

  localparam int         CNT_W    = 2 * COORD_W;
  localparam logic [3:0] LAT_INIT = 4'(PIPE_LAT);

  state_t             state_q, state_d;
  logic [COORD_W-1:0] h_q, h_d, w_q, w_d;
  logic [CNT_W-1:0]   rx_cnt_q, rx_cnt_d, rx_cnt_inc, pix_total;
  logic [3:0]         lat_q, lat_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               all_loaded_q, all_loaded_d;
  logic               frame_done_q, frame_done_d;
  logic               rx_overrun_q, rx_overrun_d;
  logic               scan_clr, scan_adv, is_border, is_last;

  pixel_scan_counter #(.COORD_W(COORD_W)) u_scan (
    .clk       (clk),
    .rst       (reset),
    .clr       (scan_clr),
    .adv       (scan_adv),
    .h         (h_q),
    .w         (w_q),
    .row       (read_H),
    .col       (read_W),
    .is_border (is_border),
    .is_last   (is_last)
  );

  assign pix_total  = {{COORD_W{1'b0}}, h_q} * {{COORD_W{1'b0}}, w_q};
  assign rx_cnt_inc = rx_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    w_d          = w_q;
    rx_cnt_d     = rx_cnt_q;
    lat_d        = lat_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    all_loaded_d = all_loaded_q;
    frame_done_d = 1'b0;
    rx_overrun_d = rx_overrun_q | (rx_valid && (state_q != ST_LOAD));
    scan_clr     = 1'b0;
    scan_adv     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        h_d      = H;
        w_d      = W;
        rx_cnt_d = '0;
        if ((H != '0) && (W != '0)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (rx_valid) begin
          rx_cnt_d = rx_cnt_inc;
          if (rx_cnt_inc == pix_total) begin
            all_loaded_d = 1'b1;
            state_d      = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (is_border) begin
          tx_data_d = BORDER_BYTE;
          state_d   = ST_SEND;
        end else begin
          lat_d   = LAT_INIT;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) begin
          tx_data_d = sobel_data;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_active) begin
          tx_valid_d = 1'b1;
          state_d    = ST_WAIT_TX;
        end
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          scan_adv = 1'b1;
          state_d  = is_last ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        frame_done_d = 1'b1;
        all_loaded_d = 1'b0;
        rx_cnt_d     = '0;
        scan_clr     = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      w_q          <= '0;
      rx_cnt_q     <= '0;
      lat_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      all_loaded_q <= 1'b0;
      frame_done_q <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      w_q          <= w_d;
      rx_cnt_q     <= rx_cnt_d;
      lat_q        <= lat_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      all_loaded_q <= all_loaded_d;
      frame_done_q <= frame_done_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign all_loaded = all_loaded_q;
  assign frame_done = frame_done_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Scoreboard bench for sobel_frame_sequencer: directed frames, UART and Sobel-pipe models.
module tb_sobel_frame_sequencer;

  localparam int CW  = 16;
  localparam int LAT = 3;

  typedef struct {
    logic [7:0]  dat;
    int          row;
    int          col;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] H = '0, W = '0;
  logic          rx_valid = 1'b0;
  logic          all_loaded;
  logic [CW-1:0] read_H, read_W;
  logic [7:0]    sobel_data = 8'hEE;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_active;
  logic          tx_done = 1'b0;
  logic          frame_done;
  logic          rx_overrun;
  logic          busy = 1'b0, force_busy = 1'b0;

  int   n_cmp = 0;
  int   n_err = 0;
  int   fd_cnt = 0;
  int   tx_pulses = 0;
  exp_t sb[$];

  assign tx_active = busy | force_busy;

  sobel_frame_sequencer #(.COORD_W(CW), .PIPE_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .H          (H),
    .W          (W),
    .rx_valid   (rx_valid),
    .all_loaded (all_loaded),
    .read_H     (read_H),
    .read_W     (read_W),
    .sobel_data (sobel_data),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .frame_done (frame_done),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sob(input int r, input int c);
    logic [7:0] v;
    v = 8'(r * 16 + c) + 8'h30;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sobel pipe: the value is only valid exactly LAT cycles after the window moves.
  initial begin
    int age;
    logic [2*CW-1:0] prev;
    age = 0;
    prev = '0;
    forever begin
      @(posedge clk); #1;
      if ({read_H, read_W} != prev) age = 0;
      else if (age < 1000) age++;
      prev = {read_H, read_W};
      sobel_data = (age == LAT) ? sob(int'(read_H), int'(read_W)) : 8'hEE;
    end
  end

  // UART transmitter: busy for a few cycles after each request, then pulses tx_done.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_valid) begin
        busy = 1'b1;
        repeat (2) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        busy = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every transmit request.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (frame_done) fd_cnt++;
      if (tx_valid) begin
        tx_pulses++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_tx: got byte %0h at (%0d,%0d) expected none", tx_data, read_H, read_W);
        end else begin
          e = sb.pop_front();
          check("tx_data", int'(tx_data), int'(e.dat));
          check("tx_row", int'(read_H), e.row);
          check("tx_col", int'(read_W), e.col);
          check("all_loaded_scan", int'(all_loaded), 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals();
    check("rst_all_loaded", int'(all_loaded), 0);
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_rx_overrun", int'(rx_overrun), 0);
    check("rst_read_H", int'(read_H), 0);
    check("rst_read_W", int'(read_W), 0);
  endtask

  task automatic run_frame(input int h, input int w, input bit inject, input bit busy_chk, input bit abort);
    int fd0, tp0;
    bit hit;
    exp_t e;
    fd0 = fd_cnt;
    if (busy_chk) force_busy = 1'b1;
    @(posedge clk); #1;
    H = CW'(h);
    W = CW'(w);
    @(posedge clk); #1;
    H = '0;
    W = '0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        e.row = r;
        e.col = c;
        e.dat = (r == 0 || c == 0 || r == h - 1 || c == w - 1) ? 8'h00 : sob(r, c);
        sb.push_back(e);
      end
    end
    for (int i = 0; i < h * w; i++) begin
      if (i == h * w - 1) check("all_loaded_pre", int'(all_loaded), 0);
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("all_loaded_post", int'(all_loaded), 1);
    if (busy_chk) begin
      tp0 = tx_pulses;
      repeat (20) @(posedge clk);
      #1;
      check("busy_hold_pulses", tx_pulses - tp0, 0);
      force_busy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("busy_release_pulses", tx_pulses - tp0, 1);
    end
    if (inject) begin
      hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(posedge clk); #1;
        if (tx_valid) begin
          hit = 1'b1;
          break;
        end
      end
      check("inject_wait", int'(hit), 1);
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      check("rx_overrun_set", int'(rx_overrun), 1);
    end
    if (abort) begin
      hit = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        @(posedge clk); #1;
        if (read_H == 2 && read_W == 1) begin
          hit = 1'b1;
          break;
        end
      end
      check("abort_wait", int'(hit), 1);
      reset = 1'b1;
      #1;
      check_reset_vals();
      sb.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      return;
    end
    hit = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (fd_cnt != fd0) begin
        hit = 1'b1;
        break;
      end
    end
    check("frame_done_seen", int'(hit), 1);
    repeat (3) @(posedge clk);
    #1;
    check("frame_done_once", fd_cnt - fd0, 1);
    check("sb_drained", sb.size(), 0);
    check("all_loaded_cleared", int'(all_loaded), 0);
    check("end_read_H", int'(read_H), 0);
    check("end_read_W", int'(read_W), 0);
  endtask

  initial begin
    int tp0;
    #2;
    check_reset_vals();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_reset_vals();

    run_frame(4, 4, 1'b0, 1'b0, 1'b0);
    run_frame(2, 5, 1'b0, 1'b0, 1'b0);
    run_frame(3, 3, 1'b0, 1'b1, 1'b0);
    check("no_overrun_yet", int'(rx_overrun), 0);

    // Zero height must keep the block idle; an rx pulse there is an overrun.
    tp0 = tx_pulses;
    @(posedge clk); #1;
    H = '0;
    W = CW'(4);
    repeat (10) @(posedge clk);
    #1;
    check("h0_all_loaded", int'(all_loaded), 0);
    check("h0_no_tx", tx_pulses - tp0, 0);
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    W = '0;
    check("h0_rx_overrun", int'(rx_overrun), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("overrun_cleared", int'(rx_overrun), 0);

    run_frame(4, 4, 1'b1, 1'b0, 1'b0);
    check("overrun_sticky", int'(rx_overrun), 1);
    run_frame(4, 4, 1'b0, 1'b0, 1'b1);
    run_frame(4, 4, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
